// File: rtl/vend_pkg.sv
// Shared types and constants for the vend payout sequencer and its coin picker.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISPENSE,
        PAY,
        WAIT_ACK,
        DONE,
        FAULT
    } state_e;

    // One-hot coin encodings, same bit positions as the coin input bus
    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_5    = 3'b100;

    localparam int unsigned COIN_VAL_1 = 1;
    localparam int unsigned COIN_VAL_2 = 2;
    localparam int unsigned COIN_VAL_5 = 5;

endpackage

// File: rtl/coin_select.sv
// Combinational greedy coin picker: largest available coin not exceeding remaining.
// With HOPPER_LOW_EN defined, empty hopper tubes are skipped.
module coin_select
    import vend_pkg::*;
#(
    parameter int unsigned CHG_W = 4
) (
    input  logic [CHG_W-1:0] remaining,
`ifdef HOPPER_LOW_EN
    input  logic [2:0]       hopper_empty,
`endif
    output logic [2:0]       coin,
    output logic [CHG_W-1:0] value,
    output logic             valid
);

    localparam logic [CHG_W-1:0] V1 = CHG_W'(COIN_VAL_1);
    localparam logic [CHG_W-1:0] V2 = CHG_W'(COIN_VAL_2);
    localparam logic [CHG_W-1:0] V5 = CHG_W'(COIN_VAL_5);

    logic [2:0] avail;

`ifdef HOPPER_LOW_EN
    assign avail = ~hopper_empty;
`else
    assign avail = 3'b111;
`endif

    always_comb begin
        coin  = COIN_NONE;
        value = '0;
        valid = 1'b0;
        if (remaining >= V5 && avail[2]) begin
            coin  = COIN_5;
            value = V5;
            valid = 1'b1;
        end else if (remaining >= V2 && avail[1]) begin
            coin  = COIN_2;
            value = V2;
            valid = 1'b1;
        end else if (remaining >= V1 && avail[0]) begin
            coin  = COIN_1;
            value = V1;
            valid = 1'b1;
        end
    end

endmodule

// File: rtl/vend_payout_sequencer.sv
// Vend controller: runs the motor until drop, then pays change one coin per hopper handshake.
// Optional HOPPER_LOW_EN adds hopper_empty so empty denominations are skipped.
module vend_payout_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned CHG_W   = 4,
    parameter int unsigned TIMEOUT = 31,
    parameter int unsigned TMR_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vend_req,
    input  logic [CHG_W-1:0] change_in,
    input  logic             drop_sense,
    output logic [2:0]       eject,
    input  logic             eject_ack,
    output logic             motor_on,
    output logic             coin_inhibit,
    output logic             busy,
    output logic             vend_done,
    output logic             fault,
`ifdef HOPPER_LOW_EN
    input  logic [2:0]       hopper_empty,
`endif
    input  logic             fault_clr
);

    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CHG_W-1:0] remaining_q, remaining_d;
    logic [CHG_W-1:0] pay_value_q, pay_value_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       eject_q, eject_d;
    logic             motor_on_q, coin_inhibit_q, busy_q, vend_done_q, fault_q;

    logic [2:0]       sel_coin;
    logic [CHG_W-1:0] sel_value;
    logic             sel_valid;

    coin_select #(
        .CHG_W(CHG_W)
    ) u_coin_select (
        .remaining    (remaining_q),
`ifdef HOPPER_LOW_EN
        .hopper_empty (hopper_empty),
`endif
        .coin         (sel_coin),
        .value        (sel_value),
        .valid        (sel_valid)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pay_value_d = pay_value_q;
        timer_d     = timer_q;
        eject_d     = eject_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                eject_d = COIN_NONE;
                if (vend_req) begin
                    remaining_d = change_in;
                    state_d     = DISPENSE;
                end
            end
            DISPENSE: begin
                // Drop wins over a coincident timeout
                if (drop_sense) begin
                    timer_d = '0;
                    state_d = (remaining_q == '0) ? DONE : PAY;
                end else if (timer_q == TMR_MAX) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            PAY: begin
                timer_d = '0;
                if (sel_valid) begin
                    eject_d     = sel_coin;
                    pay_value_d = sel_value;
                    state_d     = WAIT_ACK;
                end else begin
                    state_d = FAULT;
                end
            end
            WAIT_ACK: begin
                if (eject_ack) begin
                    remaining_d = remaining_q - pay_value_q;
                    eject_d     = COIN_NONE;
                    timer_d     = '0;
                    state_d     = (remaining_d == '0) ? DONE : PAY;
                end else if (timer_q == TMR_MAX) begin
                    // remaining kept for debug
                    eject_d = COIN_NONE;
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                eject_d = COIN_NONE;
                timer_d = '0;
                if (fault_clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            pay_value_q    <= '0;
            timer_q        <= '0;
            eject_q        <= COIN_NONE;
            motor_on_q     <= 1'b0;
            coin_inhibit_q <= 1'b0;
            busy_q         <= 1'b0;
            vend_done_q    <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            pay_value_q    <= pay_value_d;
            timer_q        <= timer_d;
            eject_q        <= eject_d;
            motor_on_q     <= (state_d == DISPENSE);
            coin_inhibit_q <= (state_d != IDLE);
            busy_q         <= (state_d != IDLE);
            vend_done_q    <= (state_d == DONE);
            fault_q        <= (state_d == FAULT);
        end
    end

    assign eject        = eject_q;
    assign motor_on     = motor_on_q;
    assign coin_inhibit = coin_inhibit_q;
    assign busy         = busy_q;
    assign vend_done    = vend_done_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_vend_payout_sequencer.sv
// Directed bench for vend_payout_sequencer; HOPPER_LOW_EN cases build only with that macro.
module tb_vend_payout_sequencer;

    logic       clk;
    logic       reset;
    logic       vend_req;
    logic [3:0] change_in;
    logic       drop_sense;
    logic [2:0] eject;
    logic       eject_ack;
    logic       motor_on;
    logic       coin_inhibit;
    logic       busy;
    logic       vend_done;
    logic       fault;
    logic       fault_clr;
`ifdef HOPPER_LOW_EN
    logic [2:0] hopper_empty;
`endif

    int unsigned n_checks;
    int unsigned n_errors;

    vend_payout_sequencer #(
        .CHG_W   (4),
        .TIMEOUT (31),
        .TMR_W   (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vend_req     (vend_req),
        .change_in    (change_in),
        .drop_sense   (drop_sense),
        .eject        (eject),
        .eject_ack    (eject_ack),
        .motor_on     (motor_on),
        .coin_inhibit (coin_inhibit),
        .busy         (busy),
        .vend_done    (vend_done),
        .fault        (fault),
`ifdef HOPPER_LOW_EN
        .hopper_empty (hopper_empty),
`endif
        .fault_clr    (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a vend and assert drop on the next cycle; leaves the DUT in PAY (or DONE).
    task automatic start_vend(input logic [3:0] chg);
        vend_req  = 1'b1;
        change_in = chg;
        tick();
        vend_req  = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_motor", 32'(motor_on), 32'd1);
        drop_sense = 1'b1;
        tick();
        drop_sense = 1'b0;
        check("drop_motor_off", 32'(motor_on), 32'd0);
    endtask

    // Entered with the DUT in PAY; acks the coin on the 2nd cycle it is shown.
    task automatic serve_coin(input string tag, input logic [2:0] exp_coin, input bit last);
        check({tag, "_gap"}, 32'(eject), 32'd0);
        tick();
        check({tag, "_eject"}, 32'(eject), 32'(exp_coin));
        tick();
        check({tag, "_hold"}, 32'(eject), 32'(exp_coin));
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        check({tag, "_cleared"}, 32'(eject), 32'd0);
        check({tag, "_done"}, 32'(vend_done), 32'(last));
        if (last) begin
            tick();
            check({tag, "_done_once"}, 32'(vend_done), 32'd0);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
            check({tag, "_idle_inhibit"}, 32'(coin_inhibit), 32'd0);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        vend_req   = 1'b0;
        change_in  = '0;
        drop_sense = 1'b0;
        eject_ack  = 1'b0;
        fault_clr  = 1'b0;
`ifdef HOPPER_LOW_EN
        hopper_empty = 3'b000;
`endif
        repeat (2) tick();
        check("rst_eject", 32'(eject), 32'd0);
        check("rst_motor", 32'(motor_on), 32'd0);
        check("rst_inhibit", 32'(coin_inhibit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(vend_done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b1;
        tick();

        // Ignored inputs in IDLE
        eject_ack  = 1'b1;
        drop_sense = 1'b1;
        tick();
        eject_ack  = 1'b0;
        drop_sense = 1'b0;
        check("idle_ignore_busy", 32'(busy), 32'd0);
        check("idle_ignore_eject", 32'(eject), 32'd0);

        // change 0: motor high 3 cycles, no eject, single done pulse
        vend_req  = 1'b1;
        change_in = 4'd0;
        tick();
        vend_req  = 1'b0;
        check("c0_motor_1", 32'(motor_on), 32'd1);
        check("c0_busy", 32'(busy), 32'd1);
        check("c0_inhibit", 32'(coin_inhibit), 32'd1);
        tick();
        check("c0_motor_2", 32'(motor_on), 32'd1);
        tick();
        check("c0_motor_3", 32'(motor_on), 32'd1);
        drop_sense = 1'b1;
        tick();
        drop_sense = 1'b0;
        check("c0_motor_off", 32'(motor_on), 32'd0);
        check("c0_done", 32'(vend_done), 32'd1);
        check("c0_no_eject", 32'(eject), 32'd0);
        check("c0_inhibit_in_done", 32'(coin_inhibit), 32'd1);
        tick();
        check("c0_done_once", 32'(vend_done), 32'd0);
        check("c0_busy_low", 32'(busy), 32'd0);
        check("c0_inhibit_low", 32'(coin_inhibit), 32'd0);

        // change 8: 5, 2, 1
        start_vend(4'd8);
        serve_coin("c8_a", 3'b100, 1'b0);
        serve_coin("c8_b", 3'b010, 1'b0);
        serve_coin("c8_c", 3'b001, 1'b1);

        // change 15: 5, 5, 5
        start_vend(4'd15);
        serve_coin("c15_a", 3'b100, 1'b0);
        serve_coin("c15_b", 3'b100, 1'b0);
        serve_coin("c15_c", 3'b100, 1'b1);

        // Drop timeout: fault on the 32nd cycle after DISPENSE entry
        vend_req  = 1'b1;
        change_in = 4'd3;
        tick();
        vend_req = 1'b0;
        repeat (31) tick();
        check("to_motor_still_on", 32'(motor_on), 32'd1);
        check("to_no_fault_yet", 32'(fault), 32'd0);
        tick();
        check("to_fault", 32'(fault), 32'd1);
        check("to_motor_off", 32'(motor_on), 32'd0);
        check("to_busy", 32'(busy), 32'd1);
        check("to_inhibit", 32'(coin_inhibit), 32'd1);
        repeat (3) tick();
        check("to_sticky", 32'(fault), 32'd1);
        // vend_req with fault_clr: back to IDLE, request dropped
        vend_req  = 1'b1;
        fault_clr = 1'b1;
        tick();
        vend_req  = 1'b0;
        fault_clr = 1'b0;
        check("clr_fault", 32'(fault), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        tick();
        check("clr_req_dropped", 32'(motor_on), 32'd0);

        // Drop coincident with timer==TIMEOUT: drop wins
        vend_req  = 1'b1;
        change_in = 4'd0;
        tick();
        vend_req = 1'b0;
        repeat (31) tick();
        drop_sense = 1'b1;
        tick();
        drop_sense = 1'b0;
        check("race_done", 32'(vend_done), 32'd1);
        check("race_no_fault", 32'(fault), 32'd0);
        tick();

        // Ack timeout in WAIT_ACK
        start_vend(4'd1);
        tick();
        check("ackto_eject", 32'(eject), 32'd1);
        repeat (31) tick();
        check("ackto_held", 32'(eject), 32'd1);
        check("ackto_no_fault", 32'(fault), 32'd0);
        tick();
        check("ackto_fault", 32'(fault), 32'd1);
        check("ackto_eject_off", 32'(eject), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("ackto_clr", 32'(fault), 32'd0);

        // Async reset while 010 is held in WAIT_ACK
        start_vend(4'd2);
        tick();
        check("ar_eject", 32'(eject), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("ar_eject_0", 32'(eject), 32'd0);
        check("ar_busy_0", 32'(busy), 32'd0);
        check("ar_inhibit_0", 32'(coin_inhibit), 32'd0);
        check("ar_motor_0", 32'(motor_on), 32'd0);
        check("ar_done_0", 32'(vend_done), 32'd0);
        check("ar_fault_0", 32'(fault), 32'd0);
        tick();
        check("ar_no_done", 32'(vend_done), 32'd0);
        reset = 1'b1;
        tick();
        start_vend(4'd1);
        serve_coin("ar_clean", 3'b001, 1'b1);

`ifdef HOPPER_LOW_EN
        hopper_empty = 3'b100;
        start_vend(4'd9);
        serve_coin("hl_a", 3'b010, 1'b0);
        serve_coin("hl_b", 3'b010, 1'b0);
        serve_coin("hl_c", 3'b010, 1'b0);
        serve_coin("hl_d", 3'b010, 1'b0);
        serve_coin("hl_e", 3'b001, 1'b1);
        hopper_empty = 3'b011;
        start_vend(4'd3);
        tick();
        check("hl_fault", 32'(fault), 32'd1);
        check("hl_no_eject", 32'(eject), 32'd0);
        fault_clr = 1'b1;
        tick();
        fault_clr    = 1'b0;
        hopper_empty = 3'b000;
        check("hl_clr", 32'(fault), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_payout_sequencer.md
Name: vend_payout_sequencer

Overview:
Controller placed downstream of the coin-accumulation logic. On a vend request it runs the product motor until a drop is sensed, then pays out the change amount one coin at a time. Each coin ejection is a req/ack handshake with the coin hopper, and the coin encoding matches the coin input bus. While a vend is in progress it holds coin acceptance inhibited, and it enters a sticky fault on any handshake timeout.

Parameters:
CHG_W, 4, width of change amount (max payout 2^CHG_W-1 = 15)
TIMEOUT, 31, max cycles waiting for drop_sense or eject_ack before FAULT (>=1)
TMR_W, 5, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
vend_req  in  1  single-cycle pulse: product paid, start vend
change_in  in  CHG_W  change owed, sampled with vend_req
drop_sense  in  1  product-drop sensor, level
eject  out  3  coin eject request, one-hot: 3'b001=1, 3'b010=2, 3'b100=5, 3'b000=none
eject_ack  in  1  hopper confirms coin ejected (1-cycle pulse)
motor_on  out  1  product dispense motor enable
coin_inhibit  out  1  reject coins at acceptor while high
busy  out  1  sequencer not in IDLE
vend_done  out  1  1-cycle pulse on successful completion
fault  out  1  sticky fault flag
fault_clr  in  1  clears FAULT, returns to IDLE

Behaviour:
- All outputs are registered. On reset: state=IDLE, remaining=0, timer=0, eject=0, motor_on=0, coin_inhibit=0, busy=0, vend_done=0, fault=0. Reset asserted mid-operation aborts immediately with no completion pulse.
- IDLE:
  - vend_req=1 latches change_in into remaining and moves to DISPENSE.
  - motor_on, busy and coin_inhibit go high in the cycle after the vend_req edge.
- DISPENSE: motor_on=1, timer increments each cycle.
  - drop_sense=1 sets motor_on=0 next cycle. Next state is DONE if remaining==0, else PAY.
  - timer==TIMEOUT without drop moves to FAULT.
- PAY (1 cycle): greedy coin select. remaining>=5 gives 3'b100, else >=2 gives 3'b010, else 3'b001. Registers eject, clears timer, moves to WAIT_ACK.
- WAIT_ACK: eject held stable.
  - eject_ack=1: subtract the coin value from remaining and set eject=0 next cycle. Next state is DONE if the result is 0, else PAY. This guarantees at least one idle eject cycle between coins.
  - timer==TIMEOUT moves to FAULT; remaining is kept for debug.
- DONE: vend_done=1 for exactly 1 cycle, then IDLE. coin_inhibit and busy drop when IDLE is entered.
- FAULT: fault=1, motor_on=0, eject=0, coin_inhibit=1, busy=1. Only fault_clr=1 exits, to IDLE next cycle (fault=0).
- Ignored inputs:
  - vend_req outside IDLE.
  - eject_ack outside WAIT_ACK.
  - drop_sense outside DISPENSE.
- If drop_sense and timer==TIMEOUT occur in the same cycle, drop_sense wins.
- If vend_req and fault_clr arrive together in FAULT, the next state is IDLE and the vend_req is dropped.
- remaining never underflows: the selected coin value is always <= remaining.

Optional Feature:
Macro HOPPER_LOW_EN.
- Defined: adds input hopper_empty[2:0], same one-hot positions as eject. Greedy select skips empty denominations, choosing the largest non-empty coin with value <= remaining. If no coin qualifies, PAY moves to FAULT.
- Undefined: port absent; hopper treated as never empty.

Decomposition:
- Shared package vend_pkg:
  - state enum (IDLE, DISPENSE, PAY, WAIT_ACK, DONE, FAULT)
  - coin encodings COIN_1/COIN_2/COIN_5 (3'b001/010/100)
  - coin value constants 1/2/5
- One natural sub-module: coin_select, combinational greedy picker. Inputs: remaining and (optionally) hopper_empty. Outputs: one-hot coin and its value. Reused by any future change-making logic.

Test Plan:
- vend_req with change_in=0, drop_sense asserted 3 cycles later: motor_on high 3 cycles, no eject, vend_done pulses once, busy low after.
- change_in=8, ack each eject after 2 cycles: eject sequence 100, 010, 001 with a 000 gap between, vend_done after the 3rd ack, remaining=0.
- change_in=15: three ejects of 100, then vend_done.
- drop_sense never asserted, TIMEOUT=31: fault=1 at cycle 32 after DISPENSE entry, motor_on=0. fault_clr returns to IDLE with fault=0.
- reset pulled low while eject=010 held in WAIT_ACK: all outputs 0 asynchronously; a vend_req after release starts a clean vend.
- HOPPER_LOW_EN with hopper_empty=3'b100 and change_in=9: ejects 010, 010, 010, 010, 001. With hopper_empty=3'b011 and change_in=3: FAULT from PAY with no eject.
